// File: rtl/am29_pkg.sv
// Shared constants for the Am2910-style next-address control slice:
// opcodes, sequencer mux select codes and the address/counter width.
package am29_pkg;

  localparam int AW = 12;

  localparam logic [3:0] OP_JZ   = 4'h0;
  localparam logic [3:0] OP_CJS  = 4'h1;
  localparam logic [3:0] OP_JMAP = 4'h2;
  localparam logic [3:0] OP_CJP  = 4'h3;
  localparam logic [3:0] OP_PUSH = 4'h4;
  localparam logic [3:0] OP_JSRP = 4'h5;
  localparam logic [3:0] OP_CJV  = 4'h6;
  localparam logic [3:0] OP_JRP  = 4'h7;
  localparam logic [3:0] OP_RFCT = 4'h8;
  localparam logic [3:0] OP_RPCT = 4'h9;
  localparam logic [3:0] OP_CRTN = 4'hA;
  localparam logic [3:0] OP_CJPP = 4'hB;
  localparam logic [3:0] OP_LDCT = 4'hC;
  localparam logic [3:0] OP_LOOP = 4'hD;
  localparam logic [3:0] OP_CONT = 4'hE;
  localparam logic [3:0] OP_TWB  = 4'hF;

  localparam logic [1:0] SEL_PC  = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_D   = 2'b11;

endpackage

// File: rtl/seq_loop_counter.sv
// Loop counter for the next-address controller: load has priority over
// decrement; the decoder only ever decrements a non-zero count.
module seq_loop_counter
  import am29_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [AW-1:0] din,
  output logic          cnt_zero
);

  logic [AW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= din;
    end else if (dec) begin
      cnt <= cnt - AW'(1);
    end
  end

  assign cnt_zero = (cnt == '0);

endmodule

// File: rtl/am2910_next_addr_ctrl.sv
// Next-address control stage: microword pipeline register, 16-opcode decode
// and loop counter driving the Am2911 slice controls and D-bus source enables.
module am2910_next_addr_ctrl
  import am29_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic [3:0]    uw_op,
  input  logic [AW-1:0] uw_ba,
  input  logic          uw_ld_ar,
  input  logic          test,
  input  logic          hold,
  output logic [AW-1:0] ba,
  output logic          s1,
  output logic          s0,
  output logic          fe,
  output logic          pup,
  output logic          zero,
  output logic          re,
  output logic          cin,
  output logic          pl_en_n,
  output logic          map_en_n,
  output logic          vect_en_n,
  output logic          cnt_zero
);

  logic [3:0] op;
  logic       ld_ar;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op    <= OP_JZ;
      ba    <= '0;
      ld_ar <= 1'b0;
    end else if (!hold) begin
      op    <= uw_op;
      ba    <= uw_ba;
      ld_ar <= uw_ld_ar;
    end
  end

  logic [1:0] sel_d;
  logic       fe_d, pup_d, zero_d, pl_d, map_d, vect_d;
  logic       cnt_ld_d, cnt_dec_d;
  logic       nz;

  assign nz = ~cnt_zero;

  always_comb begin
    sel_d     = SEL_PC;
    fe_d      = 1'b1;
    pup_d     = 1'b0;
    zero_d    = 1'b1;
    pl_d      = 1'b0;
    map_d     = 1'b1;
    vect_d    = 1'b1;
    cnt_ld_d  = 1'b0;
    cnt_dec_d = 1'b0;
    case (op)
      OP_JZ:   zero_d = 1'b0;
      OP_CJS:  if (test) begin sel_d = SEL_D; fe_d = 1'b0; pup_d = 1'b1; end
      OP_JMAP: begin sel_d = SEL_D; pl_d = 1'b1; map_d = 1'b0; end
      OP_CJP:  if (test) sel_d = SEL_D;
      OP_PUSH: begin fe_d = 1'b0; pup_d = 1'b1; cnt_ld_d = test; end
      OP_JSRP: begin fe_d = 1'b0; pup_d = 1'b1; sel_d = test ? SEL_D : SEL_AR; end
      OP_CJV:  if (test) begin sel_d = SEL_D; pl_d = 1'b1; vect_d = 1'b0; end
      OP_JRP:  sel_d = test ? SEL_D : SEL_AR;
      OP_RFCT: if (nz) begin sel_d = SEL_STK; cnt_dec_d = 1'b1; end
               else fe_d = 1'b0;
      OP_RPCT: if (nz) begin sel_d = SEL_D; cnt_dec_d = 1'b1; end
      OP_CRTN: if (test) begin sel_d = SEL_STK; fe_d = 1'b0; end
      OP_CJPP: if (test) begin sel_d = SEL_D; fe_d = 1'b0; end
      OP_LDCT: cnt_ld_d = 1'b1;
      OP_LOOP: if (test) fe_d = 1'b0;
               else sel_d = SEL_STK;
      OP_CONT: ;
      OP_TWB: begin
        if (test) fe_d = 1'b0;
        else if (nz) begin sel_d = SEL_STK; cnt_dec_d = 1'b1; end
        else begin sel_d = SEL_D; fe_d = 1'b0; end
      end
      default: ;
    endcase
  end

  // Stall: PC reselects itself with carry-in off, so the sequencer holds.
  assign {s1, s0}  = hold ? SEL_PC : sel_d;
  assign fe        = hold | fe_d;
  assign pup       = ~hold & pup_d;
  assign zero      = hold | zero_d;
  assign cin       = ~hold;
  assign re        = hold | ~ld_ar;
  assign pl_en_n   = ~hold & pl_d;
  assign map_en_n  = hold | map_d;
  assign vect_en_n = hold | vect_d;

  seq_loop_counter u_cnt (
    .clock    (clock),
    .reset    (reset),
    .load     (~hold & cnt_ld_d),
    .dec      (~hold & cnt_dec_d),
    .din      (ba),
    .cnt_zero (cnt_zero)
  );

endmodule

// File: tb/tb_am2910_next_addr_ctrl.sv
// Self-checking bench: directed microprogram fragments against a behavioural
// model of the next-address rules, checked on every falling clock edge.
module tb_am2910_next_addr_ctrl;
  import am29_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic [3:0]    uw_op;
  logic [AW-1:0] uw_ba;
  logic          uw_ld_ar;
  logic          test;
  logic          hold;
  logic [AW-1:0] ba;
  logic          s1, s0, fe, pup, zero, re, cin;
  logic          pl_en_n, map_en_n, vect_en_n, cnt_zero;

  int n_pass = 0;
  int n_total = 0;

  am2910_next_addr_ctrl dut (
    .clock(clock), .reset(reset), .uw_op(uw_op), .uw_ba(uw_ba),
    .uw_ld_ar(uw_ld_ar), .test(test), .hold(hold), .ba(ba),
    .s1(s1), .s0(s0), .fe(fe), .pup(pup), .zero(zero), .re(re), .cin(cin),
    .pl_en_n(pl_en_n), .map_en_n(map_en_n), .vect_en_n(vect_en_n),
    .cnt_zero(cnt_zero)
  );

  always #5 clock = ~clock;

  // Behavioural model: next-address source, stack action, counter action.
  localparam int SRC_PC = 0, SRC_AR = 1, SRC_STK = 2, SRC_D = 3;
  localparam int STK_NONE = 0, STK_PUSH = 1, STK_POP = 2;
  localparam int CNT_KEEP = 0, CNT_LOAD = 1, CNT_DEC = 2;
  localparam int DB_PL = 0, DB_MAP = 1, DB_VECT = 2;

  typedef struct {
    int src;
    int stk;
    int cnt;
    int dbus;
    bit clr;
  } act_t;

  logic [3:0] m_op;
  int         m_ba;
  bit         m_ld_ar;
  int         m_cnt;

  function automatic act_t model_act(input int op, input bit p, input bit nz);
    act_t a;
    a.src = SRC_PC; a.stk = STK_NONE; a.cnt = CNT_KEEP; a.dbus = DB_PL; a.clr = 0;
    case (op)
      0:  a.clr = 1;
      1:  if (p) begin a.src = SRC_D; a.stk = STK_PUSH; end
      2:  begin a.src = SRC_D; a.dbus = DB_MAP; end
      3:  if (p) a.src = SRC_D;
      4:  begin a.stk = STK_PUSH; if (p) a.cnt = CNT_LOAD; end
      5:  begin a.stk = STK_PUSH; a.src = p ? SRC_D : SRC_AR; end
      6:  if (p) begin a.src = SRC_D; a.dbus = DB_VECT; end
      7:  a.src = p ? SRC_D : SRC_AR;
      8:  if (nz) begin a.src = SRC_STK; a.cnt = CNT_DEC; end else a.stk = STK_POP;
      9:  if (nz) begin a.src = SRC_D; a.cnt = CNT_DEC; end
      10: if (p) begin a.src = SRC_STK; a.stk = STK_POP; end
      11: if (p) begin a.src = SRC_D; a.stk = STK_POP; end
      12: a.cnt = CNT_LOAD;
      13: if (p) a.stk = STK_POP; else a.src = SRC_STK;
      14: ;
      default: begin
        if (p) a.stk = STK_POP;
        else if (nz) begin a.src = SRC_STK; a.cnt = CNT_DEC; end
        else begin a.src = SRC_D; a.stk = STK_POP; end
      end
    endcase
    return a;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_op <= 4'h0; m_ba <= 0; m_ld_ar <= 0; m_cnt <= 0;
    end else if (!hold) begin
      act_t a;
      a = model_act(int'(m_op), test, m_cnt != 0);
      if (a.cnt == CNT_LOAD) m_cnt <= m_ba;
      else if (a.cnt == CNT_DEC) m_cnt <= m_cnt - 1;
      m_op <= uw_op; m_ba <= int'(uw_ba); m_ld_ar <= uw_ld_ar;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all(input string tag);
    act_t a;
    int exp_src, exp_fe, exp_pup, exp_zero;
    a = model_act(int'(m_op), test, m_cnt != 0);
    if (hold) begin
      exp_src = SRC_PC; exp_fe = 1; exp_pup = 0; exp_zero = 1;
      a.dbus = DB_PL;
    end else begin
      exp_src  = a.src;
      exp_fe   = (a.stk == STK_NONE) ? 1 : 0;
      exp_pup  = (a.stk == STK_PUSH) ? 1 : 0;
      exp_zero = a.clr ? 0 : 1;
    end
    chk({tag, ".s"},    int'({s1, s0}), exp_src);
    chk({tag, ".fe"},   int'(fe), exp_fe);
    chk({tag, ".pup"},  int'(pup), exp_pup);
    chk({tag, ".zero"}, int'(zero), exp_zero);
    chk({tag, ".cin"},  int'(cin), hold ? 0 : 1);
    chk({tag, ".re"},   int'(re), (hold || !m_ld_ar) ? 1 : 0);
    chk({tag, ".ba"},   int'(ba), m_ba);
    chk({tag, ".cnt_zero"}, int'(cnt_zero), (m_cnt == 0) ? 1 : 0);
    chk({tag, ".pl_en_n"},   int'(pl_en_n), (a.dbus == DB_PL) ? 0 : 1);
    chk({tag, ".map_en_n"},  int'(map_en_n), (a.dbus == DB_MAP) ? 0 : 1);
    chk({tag, ".vect_en_n"}, int'(vect_en_n), (a.dbus == DB_VECT) ? 0 : 1);
    chk({tag, ".onehot"}, $countones({pl_en_n, map_en_n, vect_en_n}), 2);
  endtask

  always @(negedge clock) check_all("cyc");

  task automatic cyc(input logic [3:0] o, input logic [AW-1:0] b, input logic l,
                     input logic t, input logic h);
    uw_op = o; uw_ba = b; uw_ld_ar = l; test = t; hold = h;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; uw_op = OP_CONT; uw_ba = '0; uw_ld_ar = 1'b0; test = 1'b0; hold = 1'b0;
    #3;
    chk("rst.zero", int'(zero), 0);
    chk("rst.fe", int'(fe), 1);
    chk("rst.s", int'({s1, s0}), 0);
    chk("rst.cin", int'(cin), 1);
    chk("rst.re", int'(re), 1);
    chk("rst.cnt_zero", int'(cnt_zero), 1);
    chk("rst.enables", int'({pl_en_n, map_en_n, vect_en_n}), 3'b011);
    @(posedge clock); #1;
    reset = 1'b0;
    #1 chk("first_fetch.zero", int'(zero), 0);

    // CJS, both test outcomes
    cyc(OP_CJS, 12'h123, 1'b0, 1'b0, 1'b0);
    test = 1'b1;
    #1 chk("cjs_p.s", int'({s1, s0}), 3);
    chk("cjs_p.fe", int'(fe), 0);
    chk("cjs_p.pup", int'(pup), 1);
    chk("cjs_p.ba", int'(ba), 12'h123);
    test = 1'b0;
    #1 chk("cjs_np.s", int'({s1, s0}), 0);
    chk("cjs_np.fe", int'(fe), 1);

    // LDCT 3 then RPCT loop
    cyc(OP_LDCT, 12'd3, 1'b0, 1'b0, 1'b0);
    cyc(OP_RPCT, 12'h040, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("rpct_loop.s", int'({s1, s0}), 3);
      chk("rpct_loop.cnt_zero", int'(cnt_zero), 0);
      cyc(OP_RPCT, 12'h040, 1'b0, 1'b0, 1'b0);
    end
    #1 chk("rpct_done.s", int'({s1, s0}), 0);
    chk("rpct_done.cnt_zero", int'(cnt_zero), 1);

    // TWB with counter 2, test = 0
    cyc(OP_LDCT, 12'd2, 1'b0, 1'b0, 1'b0);
    cyc(OP_TWB, 12'h0AA, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1 chk("twb_dec.s", int'({s1, s0}), 2);
      chk("twb_dec.fe", int'(fe), 1);
      cyc(OP_TWB, 12'h0AA, 1'b0, 1'b0, 1'b0);
    end
    #1 chk("twb_end.s", int'({s1, s0}), 3);
    chk("twb_end.fe", int'(fe), 0);
    chk("twb_end.pup", int'(pup), 0);

    // TWB with counter 2, test = 1: exits at once, counter untouched
    cyc(OP_LDCT, 12'd2, 1'b0, 1'b0, 1'b0);
    cyc(OP_TWB, 12'h0BB, 1'b0, 1'b1, 1'b0);
    #1 chk("twb_p.s", int'({s1, s0}), 0);
    chk("twb_p.fe", int'(fe), 0);
    chk("twb_p.pup", int'(pup), 0);
    cyc(OP_RPCT, 12'h050, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      #1 chk("twb_keep.s", int'({s1, s0}), 3);
      cyc(OP_RPCT, 12'h050, 1'b0, 1'b0, 1'b0);
    end
    #1 chk("twb_keep.done", int'({s1, s0}), 0);

    // Hold 3 cycles over JMAP
    cyc(OP_JMAP, 12'h2A5, 1'b1, 1'b0, 1'b0);
    uw_op = OP_CONT; uw_ba = 12'h777; uw_ld_ar = 1'b0; hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold.cin", int'(cin), 0);
      chk("hold.fe", int'(fe), 1);
      chk("hold.re", int'(re), 1);
      chk("hold.ba", int'(ba), 12'h2A5);
      @(posedge clock); #1;
    end
    hold = 1'b0;
    #1 chk("jmap.map_en_n", int'(map_en_n), 0);
    chk("jmap.pl_en_n", int'(pl_en_n), 1);
    chk("jmap.s", int'({s1, s0}), 3);
    chk("jmap.cin", int'(cin), 1);
    chk("jmap.re", int'(re), 0);
    cyc(OP_CONT, 12'h777, 1'b0, 1'b0, 1'b0);
    #1 chk("after_hold.ba", int'(ba), 12'h777);

    // Sweep every opcode x test x counter state
    for (int op = 0; op < 16; op++) begin
      for (int cz = 0; cz < 2; cz++) begin
        cyc(OP_LDCT, (cz != 0) ? 12'd0 : 12'd5, 1'b0, 1'b0, 1'b0);
        cyc(4'(op), 12'h0C0 + 12'(op), 1'(op & 1), 1'b0, 1'b0);
        for (int t = 0; t < 2; t++) begin
          test = 1'(t);
          #1 check_all("sweep");
        end
      end
    end

    // Asynchronous reset mid-loop
    cyc(OP_LDCT, 12'd5, 1'b0, 1'b0, 1'b0);
    cyc(OP_RPCT, 12'h060, 1'b0, 1'b0, 1'b0);
    cyc(OP_RPCT, 12'h060, 1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 chk("async_rst.zero", int'(zero), 0);
    chk("async_rst.cnt_zero", int'(cnt_zero), 1);
    chk("async_rst.ba", int'(ba), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    #1 chk("rst_release.zero", int'(zero), 0);
    cyc(OP_CONT, 12'h001, 1'b0, 1'b0, 1'b0);
    #1 chk("post_rst.cont_zero", int'(zero), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/am2910_next_addr_ctrl.md
# am2910_next_addr_ctrl

- Next-address control stage directly upstream of the Am2911 sequencer slices.
- Holds the microword pipeline register: opcode, branch address and AR-load bit.
- Decodes the 16 Am29811-style next-address instructions against a test condition and an internal 12-bit loop counter.
- Drives the slice controls s1/s0, fe, pup, zero, re and cin, plus the one-hot source enables for the sequencer D bus.

## Interface
- `AW`, 12: branch-address / loop-counter width (three 4-bit slices).
- `clock`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `uw_op`  in  4  next-address opcode field from microcode ROM output.
- `uw_ba`  in  AW  branch address / counter-load field from ROM.
- `uw_ld_ar`  in  1  load-AR bit from ROM.
- `test`  in  1  selected condition; 1 = pass.
- `hold`  in  1  stall: freeze pipeline, counter and sequencer PC.
- `ba`  out  AW  registered branch field; drives the sequencer D bus when `pl_en_n` = 0.
- `s1`, `s0`  out  1 each  slice mux select: 00 PC, 01 AR, 10 stack, 11 D.
- `fe`  out  1  stack enable, active-low.
- `pup`  out  1  1 = push, 0 = pop.
- `zero`  out  1  active-low force-zero.
- `re`  out  1  active-low AR load.
- `cin`  out  1  incrementer carry into LSB slice.
- `pl_en_n`, `map_en_n`, `vect_en_n`  out  1 each  one-hot-low D-bus source enables.
- `cnt_zero`  out  1  loop counter equals 0.

## Operation
- Pipeline register: `op`, `ba`, `ld_ar` load from `uw_*` every edge with `hold` = 0.
- Default decode (applies unless the opcode says otherwise): s = 00, fe = 1, pup = 0, zero = 1, cin = 1, `pl_en_n` = 0.
- `re` = ~`ld_ar`, except forced to 1 while `hold` = 1.
- Terminology: "push" = fe 0, pup 1. "pop" = fe 0, pup 0. "load" = counter ← `ba`. "dec" = counter − 1.
- "nz" means counter ≠ 0. "P" means `test` = 1.
- Opcode behaviour:
  - 0 JZ: zero = 0.
  - 1 CJS: P: D, push. !P: PC.
  - 2 JMAP: D with `map_en_n` = 0.
  - 3 CJP: P: D. !P: PC.
  - 4 PUSH: PC, push. P: also load.
  - 5 JSRP: push always. P: D. !P: AR.
  - 6 CJV: P: D with `vect_en_n` = 0. !P: PC.
  - 7 JRP: P: D. !P: AR.
  - 8 RFCT: nz: stack, dec. zero: PC, pop.
  - 9 RPCT: nz: D, dec. zero: PC.
  - A CRTN: P: stack, pop. !P: PC.
  - B CJPP: P: D, pop. !P: PC.
  - C LDCT: PC, load.
  - D LOOP: P: PC, pop. !P: stack.
  - E CONT: PC.
  - F TWB: P: PC, pop. !P with nz: stack, dec. !P with counter zero: D, pop.
- Counter priority: load > dec > hold.
  - Dec from 0 never occurs: dec is only issued when nz.
  - 12-bit unsigned; no wrap path exists.
- `hold` = 1 overrides decode: s = 00, fe = 1, zero = 1, cin = 0, `re` = 1. The sequencer PC therefore reloads its own value.
- Reset values:
  - `op` = 0 (JZ), `ba` = 0, `ld_ar` = 0, counter = 0.
  - Resulting outputs: zero = 0, fe = 1, pup = 0, s = 00, cin = 1, re = 1, `pl_en_n` = 0, `map_en_n` = 1, `vect_en_n` = 1, `cnt_zero` = 1.
  - The first post-reset microaddress is therefore 0.

## Timing
- All outputs are combinational from registered state plus `test` and `hold`; no extra cycle of latency.
- The ROM word for address N is captured on the same edge at which the sequencer presents N+1. This is the classic one-level pipeline.
- Counter update, stack push/pop and PC update all occur on the same rising edge.
- `test` must settle before the setup window of that edge.
- Reset asserts asynchronously and forces JZ decode immediately.
- Reset deassertion mid-loop discards the counter and pipeline contents.
- `hold` asserted for k cycles delays execution by exactly k cycles. The held instruction then executes once, unchanged, on the first edge with `hold` = 0.

## Structure
- Shared package `am29_pkg`: opcode constants `OP_JZ` … `OP_TWB`, the s-select encoding `SEL_PC`/`SEL_AR`/`SEL_STK`/`SEL_D`, and `AW`.
- Sub-module `seq_loop_counter` (load, dec, `cnt_zero`, async reset).
- Decode stays in the parent as one combinational case on `op`.

## Test plan
- Reset pulse mid-run → zero = 0 with no clock edge. The first fetched address after release is 0x000.
- CJS with `test` = 1 and `ba` = 0x123 → s = 11, fe = 0, pup = 1. With `test` = 0 → s = 00, fe = 1.
- LDCT with `ba` = 3, then RPCT with `ba` = 0x040 → D selected on three successive RPCT cycles (counter 3→2→1→0). The fourth RPCT selects PC and `cnt_zero` = 1.
- TWB with counter 2 and `test` = 0 → stack, dec twice, then D with pop. Repeat with `test` = 1 on the first cycle → PC, pop, counter left at 2.
- `hold` = 1 for 3 cycles during JMAP → cin = 0, fe = 1 and pipeline frozen throughout. JMAP then executes once with `map_en_n` = 0.
- Sweep all 16 opcodes × `test` ∈ {0, 1} × `cnt_zero` ∈ {0, 1} → outputs match the decode above, and exactly one D-bus source enable is low.
